// File: rtl/fp_cmp_pkg.sv
// Shared encodings for the FloPoCo-format comparator: exception codes,
// predicate codes and the word-width helper.
package fp_cmp_pkg;

  localparam logic [1:0] EXN_ZERO = 2'b00;
  localparam logic [1:0] EXN_NORM = 2'b01;
  localparam logic [1:0] EXN_INF  = 2'b10;
  localparam logic [1:0] EXN_NAN  = 2'b11;

  localparam logic [2:0] OP_GE = 3'b000;
  localparam logic [2:0] OP_GT = 3'b001;
  localparam logic [2:0] OP_LE = 3'b010;
  localparam logic [2:0] OP_LT = 3'b011;
  localparam logic [2:0] OP_EQ = 3'b100;
  localparam logic [2:0] OP_NE = 3'b101;

  function automatic int fp_width(input int we, input int wf);
    return we + wf + 3;
  endfunction

endpackage

// File: rtl/fp_cmp_lane.sv
// One comparator lane: builds sign-free order keys for both operands and
// registers the magnitude compare plus the exception/sign decode (stage 1).
module fp_cmp_lane
  import fp_cmp_pkg::*;
#(
  parameter  int WE = 5,
  parameter  int WF = 11,
  localparam int W  = fp_width(WE, WF)
) (
  input  logic         clk,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         nan_p1,
  output logic         sign_a_p1,
  output logic         sign_b_p1,
  output logic         zero_p1,
  output logic         key_lt_p1,
  output logic         key_eq_p1
);

  localparam int KW = WE + WF + 2;

  // Exception class sits above exp/frac, so zero < normal < inf falls out
  // of a plain unsigned compare; NaN keys are never consulted.
  function automatic logic [KW-1:0] order_key(input logic [W-1:0] x);
    case (x[W-1 -: 2])
      EXN_NORM: order_key = {2'b01, x[WE+WF-1:0]};
      EXN_INF:  order_key = {2'b10, {(KW-2){1'b0}}};
      default:  order_key = '0;
    endcase
  endfunction

  logic [KW-1:0] key_a, key_b;

  assign key_a = order_key(a);
  assign key_b = order_key(b);

  // ---- stage 1 boundary ----
  always_ff @(posedge clk) begin
    if (en) begin
      nan_p1    <= (a[W-1 -: 2] == EXN_NAN) || (b[W-1 -: 2] == EXN_NAN);
      zero_p1   <= (a[W-1 -: 2] == EXN_ZERO) && (b[W-1 -: 2] == EXN_ZERO);
      sign_a_p1 <= a[W-3];
      sign_b_p1 <= b[W-3];
      key_lt_p1 <= key_a < key_b;
      key_eq_p1 <= key_a == key_b;
    end
  end

endmodule

// File: rtl/fp_compare_pipe.sv
// Multi-lane, two-stage FloPoCo float comparator with valid/ready handshake,
// selectable predicate, NaN-aware unordered flags and lane reductions.
module fp_compare_pipe
  import fp_cmp_pkg::*;
#(
  parameter  int WE    = 5,
  parameter  int WF    = 11,
  parameter  int LANES = 3,
  parameter  int TAG_W = 4,
  localparam int W     = fp_width(WE, WF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic [LANES*W-1:0] in_a,
  input  logic [LANES*W-1:0] in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES-1:0]   out_result,
  output logic [LANES-1:0]   out_unord,
  output logic               out_all,
  output logic               out_any,
  output logic [TAG_W-1:0]   out_tag
);

  // Signed ordering from the sign-free key compare, then predicate select.
  // Reserved ops win over NaN so they always yield 0.
  function automatic logic predicate(input logic [2:0] op, input logic nan,
                                     input logic sa, input logic sb,
                                     input logic zero, input logic klt,
                                     input logic keq);
    logic lt, eq, gt;
    if (zero) begin
      lt = 1'b0;
      eq = 1'b1;
    end else if (sa != sb) begin
      lt = sa;
      eq = 1'b0;
    end else begin
      eq = keq;
      lt = sa ? (~klt & ~keq) : klt;
    end
    gt = ~lt & ~eq;
    if (op > OP_NE)   predicate = 1'b0;
    else if (nan)     predicate = (op == OP_NE);
    else begin
      case (op)
        OP_GE:   predicate = ~lt;
        OP_GT:   predicate = gt;
        OP_LE:   predicate = ~gt;
        OP_LT:   predicate = lt;
        OP_EQ:   predicate = eq;
        default: predicate = ~eq;
      endcase
    end
  endfunction

  logic en;
  logic vld_p1, vld_p2;
  logic [2:0]       op_p1;
  logic [TAG_W-1:0] tag_p1, tag_p2;
  logic [LANES-1:0] nan_p1, sign_a_p1, sign_b_p1, zero_p1, key_lt_p1, key_eq_p1;
  logic [LANES-1:0] res_s2;
  logic [LANES-1:0] result_p2, unord_p2;
  logic             all_p2, any_p2;

  assign en       = out_ready | ~vld_p2;
  assign in_ready = en;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp_cmp_lane #(.WE(WE), .WF(WF)) u_lane (
      .clk       (clk),
      .en        (en),
      .a         (in_a[i*W +: W]),
      .b         (in_b[i*W +: W]),
      .nan_p1    (nan_p1[i]),
      .sign_a_p1 (sign_a_p1[i]),
      .sign_b_p1 (sign_b_p1[i]),
      .zero_p1   (zero_p1[i]),
      .key_lt_p1 (key_lt_p1[i]),
      .key_eq_p1 (key_eq_p1[i])
    );
    assign res_s2[i] = predicate(op_p1, nan_p1[i], sign_a_p1[i], sign_b_p1[i],
                                 zero_p1[i], key_lt_p1[i], key_eq_p1[i]);
  end

  // ---- stage 1 boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     vld_p1 <= 1'b0;
    else if (en) vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      op_p1  <= in_op;
      tag_p1 <= in_tag;
    end
  end

  // ---- stage 2 boundary ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2    <= 1'b0;
      result_p2 <= '0;
      unord_p2  <= '0;
      all_p2    <= 1'b0;
      any_p2    <= 1'b0;
      tag_p2    <= '0;
    end else if (en) begin
      vld_p2    <= vld_p1;
      result_p2 <= res_s2;
      unord_p2  <= nan_p1;
      all_p2    <= &res_s2;
      any_p2    <= |res_s2;
      tag_p2    <= tag_p1;
    end
  end

  assign out_valid  = vld_p2;
  assign out_result = result_p2;
  assign out_unord  = unord_p2;
  assign out_all    = all_p2;
  assign out_any    = any_p2;
  assign out_tag    = tag_p2;

endmodule

// File: doc/fp_compare_pipe.md
Name: fp_compare_pipe

Overview:
- Pipelined, multi-lane, multi-mode comparator for FloPoCo-format floats (2-bit exception field, sign, exponent, fraction).
- Successor to the single-lane greater-or-equal check in the Ray/AABB slab datapath. Compares magnitude directly, with no subtractor, and supports parametrised formats, selectable predicates, explicit NaN/zero/inf semantics, a valid/ready handshake and a pass-through tag.
- Sits after the slab t-value computation and feeds the hit/miss decision. out_all gives the AND of all lanes, e.g. tmin<=tmax on x/y/z.

Parameters:
- WE, 5, exponent width.
- WF, 11, fraction width. Word width W = WE+WF+3.
- LANES, 3, number of independent comparisons per transaction.
- TAG_W, 4, width of the opaque tag carried alongside the data (e.g. ray ID).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  block accepts a transaction this cycle.
- in_op  in  3  predicate: 000 GE, 001 GT, 010 LE, 011 LT, 100 EQ, 101 NE, 110/111 reserved.
- in_a  in  LANES*W  lane i operand A at [i*W +: W].
- in_b  in  LANES*W  lane i operand B at [i*W +: W].
- in_tag  in  TAG_W  carried unchanged to the output.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_result  out  LANES  per-lane predicate A op B.
- out_unord  out  LANES  per-lane unordered flag (A or B is NaN).
- out_all  out  1  AND of out_result.
- out_any  out  1  OR of out_result.
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Word fields: exn = [W-1:W-2] (00 zero, 01 normal, 10 inf, 11 NaN); sign = [W-3]; exp; frac.
- Order key per operand, WE+WF+2 bits:
  - zero -> all 0;
  - normal -> {2'b01, exp, frac};
  - inf -> {2'b10, 0}.
  - Sign is ignored in the key.
- Ordering:
  - both keys 0 -> equal, so +0 == -0;
  - signs differ -> the negative operand is less;
  - both positive -> unsigned key compare;
  - both negative -> reversed key compare.
- NaN in either operand:
  - unord = 1;
  - result = 1 for NE, 0 for all other predicates.
- Reserved op: result = 0 on all lanes, unord still computed.
- Pipeline, fixed latency 2 at full throughput:
  - S1 registers the exn decode, signs, key-lt and key-eq per lane, plus op, tag and valid.
  - S2 registers lt/eq/gt -> predicate, unord, the all/any reduction, tag and valid.
- Handshake:
  - en = out_ready | ~out_valid; both stages advance only when en = 1.
  - in_ready = en, purely combinational from the S2 valid and out_ready.
  - A transfer occurs when in_valid & in_ready.
  - When en = 0, all registers hold and outputs stay stable while out_valid is high.
- Bubbles: an S1 stage with valid = 0 propagates as out_valid = 0. Data registers may update on bubbles, but out_* data are don't-care only while out_valid = 0.
- Reset (async): S1/S2 valid = 0 and out_valid = 0. out_result, out_unord, out_all, out_any and out_tag = 0. in_ready = 1 after reset.
  - Reset mid-flight flushes all in-flight transactions; nothing is emitted after deassertion.
- Back-to-back, out_ready held high: N transactions on consecutive cycles emerge on N consecutive cycles, 2 cycles later, in order.
- Back-pressure: out_ready low for k cycles with a full pipe means no loss or duplication. At most 2 transactions are resident.
- LANES = 1 must elaborate; out_all = out_any = out_result[0].

Decomposition:
- Package fp_cmp_pkg:
  - exception codes EXN_ZERO/NORM/INF/NAN;
  - op codes OP_GE..OP_NE;
  - function computing W from WE/WF.
- Sub-module fp_cmp_lane: one lane, combinational key build plus S1 compare. It is instantiated LANES times by a generate loop. The top module holds the handshake, valid/tag pipe and reduction.

Test Plan:
- Values used (WE=5, WF=11): +1.0 = 0x27800, +2.0 = 0x28000, -1.0 = 0x37800, +0 = 0x00000, -0 = 0x10000, +inf = 0x40000, NaN = 0x60000.
- Lane0 A=2.0 B=1.0, lane1 A=-1.0 B=1.0, lane2 A=1.0 B=1.0, op GE, tag 5 -> 2 cycles later out_result = 3'b101, out_all = 0, out_any = 1, out_tag = 5.
- All lanes A=+0 B=-0; ops EQ, GE, GT in consecutive cycles -> results 111, 111, 000 on 3 consecutive out_valid cycles.
- Lane0 A=NaN B=1.0, op LT then NE -> lane0 result 0 then 1, out_unord[0] = 1 both times; lane1 A=+inf B=2.0, op GT -> result 1, unord 0.
- Stream 6 transactions with tags 0..5 while holding out_ready = 0 for cycles 3-6 -> in_ready drops, outputs stable while stalled, tags emerge 0..5 exactly once and in order.
- Assert rst asynchronously with 2 transactions in flight -> out_valid = 0 immediately; no output for those tags after release; next input appears 2 cycles after acceptance.
- op = 3'b111 with A=2.0 B=1.0 -> out_result = 000, out_unord = 000, out_any = 0.
